// File: rtl/mult_rr_sched_pkg.sv
// Shared constants and types for the round-robin multiplier scheduler.
// MULT_LAT equals the pipeline depth of mult_fast and is not independently adjustable.
package mult_rr_sched_pkg;
    localparam int N_REQ_DEF = 4;
    localparam int ID_W_DEF  = 2;
    localparam int MULT_LAT  = 2;
    localparam int OP_W      = 4;
    localparam int P_W       = 8;
    localparam int CNT_W     = 2;

    typedef logic [OP_W-1:0] opnd_t;
    typedef logic [P_W-1:0]  prod_t;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/mult_fast.sv
// Pipelined unsigned 4x4 multiplier: operands registered at the accept edge,
// product visible on P two edges later. No reset; P is meaningful only when tagged valid.
module mult_fast (
    input  logic       clk,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P
);
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [5:0] pp_lo_q;
    logic [5:0] pp_hi_q;

    // Input register, then two 4x2 partial products, then the final add.
    always_ff @(posedge clk) begin
        a_q     <= A;
        b_q     <= B;
        pp_lo_q <= {2'b00, a_q} * {4'b0000, b_q[1:0]};
        pp_hi_q <= {2'b00, a_q} * {4'b0000, b_q[3:2]};
        P       <= {2'b00, pp_lo_q} + {pp_hi_q, 2'b00};
    end
endmodule

// File: rtl/mult_rr_sched_pick.sv
// Rotating-priority picker: grants the first eligible index at or after ptr_i,
// wrapping modulo N, as a one-hot vector plus its binary index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  elig_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    // Walk offsets from the pointer; only the first eligible hit is taken.
    always_comb begin
        int   j;
        logic hit;
        j     = 0;
        hit   = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            j        = (int'(ptr_i) + k) % N;
            hit      = elig_i[j] & ~any_o;
            gnt_o[j] = gnt_o[j] | hit;
            idx_o    = hit ? IW'(j) : idx_o;
            any_o    = any_o | hit;
        end
    end
endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one pipelined 4x4 multiplier between N_REQ requesters;
// each product returns tagged with its requester id exactly MULT_LAT cycles after acceptance.
module mult_rr_sched
    import mult_rr_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [OP_W*N_REQ-1:0] req_a,
    input  logic [OP_W*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]     req_mask,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [P_W-1:0]       rsp_p,
    output logic [CNT_W-1:0]     inflight
);
    logic [N_REQ-1:0] elig_s;
    logic [N_REQ-1:0] gnt_s;
    logic [ID_W-1:0]  gidx_s;
    logic             any_s;
    logic             accept_s;
    logic             ret_s;
    opnd_t            a_s;
    opnd_t            b_s;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             tag_vld_q [MULT_LAT];
    logic [ID_W-1:0]  tag_id_q  [MULT_LAT];
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    cnt_t             inflight_q, inflight_d;

    assign elig_s = req_valid & req_mask;

    rr_pick #(.N(N_REQ), .IW(ID_W)) u_pick (
        .elig_i (elig_s),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt_s),
        .idx_o  (gidx_s),
        .any_o  (any_s)
    );

    // No grant may be offered while reset is held, so nothing can be accepted then.
    assign req_ready = rst_n ? gnt_s : '0;
    assign accept_s  = any_s & rst_n;
    assign ret_s     = tag_vld_q[MULT_LAT-1];

    // Operand mux; idle cycles feed zeros so the multiplier never sees stale data.
    always_comb begin
        a_s = '0;
        b_s = '0;
        if (any_s) begin
            a_s = req_a[gidx_s*OP_W +: OP_W];
            b_s = req_b[gidx_s*OP_W +: OP_W];
        end else begin
            a_s = '0;
            b_s = '0;
        end
    end

    mult_fast u_mult (
        .clk (clk),
        .A   (a_s),
        .B   (b_s),
        .P   (rsp_p)
    );

    // Pointer advances past the granted index only when the handshake fires.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_s) begin
            ptr_d = (gidx_s == ID_W'(N_REQ-1)) ? '0 : gidx_s + ID_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Accept and return in the same cycle cancel out.
    always_comb begin
        inflight_d = inflight_q;
        case ({accept_s, ret_s})
            2'b10:   inflight_d = inflight_q + cnt_t'(1);
            2'b01:   inflight_d = inflight_q - cnt_t'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Tag pipe tracks ownership alongside the multiplier; it never stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            inflight_q  <= '0;
            for (int k = 0; k < MULT_LAT; k++) begin
                tag_vld_q[k] <= 1'b0;
                tag_id_q[k]  <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            tag_vld_q[0] <= accept_s;
            tag_id_q[0]  <= gidx_s;
            for (int k = 1; k < MULT_LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
            rsp_valid_q  <= tag_vld_q[MULT_LAT-1];
            rsp_id_q     <= tag_id_q[MULT_LAT-1];
            inflight_q   <= inflight_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign inflight  = inflight_q;
endmodule
